// File: rtl/rv32i_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the register word offsets, the STATUS bit positions and the
// transmit FSM state enum.
package rv32i_mmio_pkg;

    localparam logic [3:0] ADDR_TXDATA = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_CTRL   = 4'h8;

    localparam int unsigned ST_FULL    = 0;
    localparam int unsigned ST_EMPTY   = 1;
    localparam int unsigned ST_TXACT   = 2;
    localparam int unsigned ST_OVF     = 3;
    localparam int unsigned ST_OCC_LSB = 4;
    localparam int unsigned ST_OCC_W   = 7;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
// Ports: clk, rst (async active-low), push/din, pop/dout (show-ahead),
// full, empty, count (log2(DEPTH)+1 bits).
// full/empty come from the pre-edge count, so a push at full is dropped
// even when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a transmit FIFO.
// Ports: clk, rst (async active-low), wr_en/rd_en strobes, addr (word
// offset), wdata, rdata (registered load data), tx (serial line, idle high),
// busy (FIFO non-empty or frame in flight). Registers: TXDATA (write byte),
// STATUS (read-only flags/occupancy), CTRL (bit0 clears sticky overflow).
module uart_tx_mmio
    import rv32i_mmio_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

    tx_state_t   state, state_n;
    logic [15:0] baud, baud_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  shift, shift_n;
    logic        pop;
    logic        push;
    logic        push_ok;
    logic [7:0]  fifo_dout;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] occ_n;
    logic        overflow;
    logic        tx_d;
    logic        busy_d;
    logic [31:0] status;
    logic        unused_wdata;

    assign unused_wdata = ^wdata[31:8];
    assign push    = wr_en && (addr == ADDR_TXDATA);
    assign push_ok = push && !fifo_full;

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (wdata[7:0]),
        .pop  (pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_n = START;
                    pop     = 1'b1;
                    shift_n = fifo_dout;
                    baud_n  = BAUD_RELOAD;
                end
            end
            START: begin
                if (baud == '0) begin
                    state_n   = DATA;
                    baud_n    = BAUD_RELOAD;
                    bit_idx_n = '0;
                end else begin
                    baud_n = baud - 1'b1;
                end
            end
            DATA: begin
                if (baud == '0) begin
                    baud_n  = BAUD_RELOAD;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_idx_n = bit_idx + 1'b1;
                end else begin
                    baud_n = baud - 1'b1;
                end
            end
            STOP: begin
                if (baud == '0) begin
                    if (!fifo_empty) begin
                        state_n = START;
                        pop     = 1'b1;
                        shift_n = fifo_dout;
                        baud_n  = BAUD_RELOAD;
                    end else begin
                        state_n = IDLE;
                        baud_n  = '0;
                    end
                end else begin
                    baud_n = baud - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // tx/busy are computed from next-cycle state so the registered outputs
    // line up with the state they describe (no one-cycle lag on the line).
    always_comb begin
        case (state_n)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_n[0];
            default: tx_d = 1'b1;
        endcase
        occ_n  = fifo_count + CW'(push_ok) - CW'(pop);
        busy_d = (state_n != IDLE) || (occ_n != '0);
    end

    always_comb begin
        status                            = '0;
        status[ST_FULL]                   = fifo_full;
        status[ST_EMPTY]                  = fifo_empty;
        status[ST_TXACT]                  = (state != IDLE);
        status[ST_OVF]                    = overflow;
        status[ST_OCC_LSB +: ST_OCC_W]    = ST_OCC_W'(fifo_count);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud     <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            overflow <= 1'b0;
            rdata    <= '0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx      <= tx_d;
            busy    <= busy_d;
            if (push && fifo_full)
                overflow <= 1'b1;
            else if (wr_en && (addr == ADDR_CTRL) && wdata[0])
                overflow <= 1'b0;
            if (rd_en)
                rdata <= (addr == ADDR_STATUS) ? status : '0;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio (CLK_DIV=4, FIFO_DEPTH=4).
// Expected bytes and expected load data are queued at stimulus time; a
// serial receiver and a load monitor pop and compare independently.
module tb_uart_tx_mmio;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [3:0]  addr = 4'h0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        tx;
    logic        busy;

    uart_tx_mmio #(
        .CLK_DIV(4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    logic [7:0]  byte_q[$];
    logic [31:0] rd_q[$];
    logic rd_pending = 1'b0;
    always @(posedge clk) rd_pending <= rd_en;

    bit rx_en = 1'b0;
    int rx_start = -1;
    int rx_prev_start = -1;
    logic [7:0] rx_b;
    logic rx_startb;
    logic rx_stopb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // load monitor
    initial forever begin
        @(negedge clk);
        if (rd_pending) begin
            if (rd_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rdata_unexpected: got 0x%08h expected no load", rdata);
            end else begin
                chk("rdata", rdata, rd_q.pop_front());
            end
        end
    end

    // serial receiver, samples mid-bit
    initial forever begin
        @(negedge clk);
        if (rx_en && tx === 1'b0) begin
            rx_prev_start = rx_start;
            rx_start = cyc;
            repeat (2) @(negedge clk);
            rx_startb = tx;
            for (int i = 0; i < 8; i++) begin
                repeat (4) @(negedge clk);
                rx_b[i] = tx;
            end
            repeat (4) @(negedge clk);
            rx_stopb = tx;
            chk("start_bit", 32'(rx_startb), 32'd0);
            chk("stop_bit", 32'(rx_stopb), 32'd1);
            if (byte_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rx_unexpected: got 0x%02h expected no frame", rx_b);
            end else begin
                chk("rx_byte", 32'(rx_b), 32'(byte_q.pop_front()));
            end
        end
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1;
        rd_en = 1'b0;
        addr  = a;
        wdata = d;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b1;
        addr  = a;
        rd_q.push_back(exp);
    endtask

    task automatic idle();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic wait_idle(output int fall);
        fall = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                fall = cyc;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL busy_timeout: got busy=%b expected 0", busy);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    int fall;
    int edges;
    bit seen;

    initial begin
        // reset
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rst = 1'b1;
        rx_en = 1'b1;
        rd(4'h4, 32'h0000_0002);
        rd(4'h0, 32'h0);
        idle();

        // single frame 0x55, upper data bits ignored
        byte_q.push_back(8'h55);
        wr(4'h0, 32'hFFFF_FF55);
        idle();
        wait_idle(fall);
        chk("frame_len", 32'(fall - rx_start), 32'd40);
        rd(4'h4, 32'h0000_0002);
        idle();

        // back-to-back frames
        byte_q.push_back(8'hA5);
        byte_q.push_back(8'h3C);
        wr(4'h0, 32'h0000_00A5);
        wr(4'h0, 32'h0000_003C);
        idle();
        wait_idle(fall);
        chk("b2b_gap", 32'(rx_start - rx_prev_start), 32'd40);
        chk("two_frame_len", 32'(fall - rx_prev_start), 32'd80);

        // two queued while first is on the line
        byte_q.push_back(8'h11);
        byte_q.push_back(8'h22);
        byte_q.push_back(8'h33);
        wr(4'h0, 32'h11);
        wr(4'h0, 32'h22);
        wr(4'h0, 32'h33);
        rd(4'h4, 32'h0000_0024);
        idle();
        wait_idle(fall);

        // overflow: 6 stores, one in flight + 4 queued, 6th dropped
        for (int i = 1; i <= 5; i++) byte_q.push_back(8'(i));
        for (int i = 1; i <= 6; i++) wr(4'h0, 32'(i));
        rd(4'h4, 32'h0000_004D);
        wr(4'h8, 32'h0);
        rd(4'h4, 32'h0000_004D);
        wr(4'h8, 32'h1);
        rd(4'h4, 32'h0000_0045);
        wr(4'h4, 32'hFFFF_FFFF);
        rd(4'h4, 32'h0000_0045);
        rd(4'h8, 32'h0);
        rd(4'hC, 32'h0);
        idle();
        wait_idle(fall);
        rd(4'h4, 32'h0000_0002);
        idle();

        // reset mid-frame at frame cycle 15 (bit2 of 0xF0 is low there)
        rx_en = 1'b0;
        wr(4'h0, 32'hF0);
        idle();
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (tx === 1'b0) seen = 1'b1;
        end
        chk("abort_frame_started", 32'(seen), 32'd1);
        repeat (14) @(negedge clk);
        chk("abort_pre_tx", 32'(tx), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_tx_now", 32'(tx), 32'd1);
        repeat (2) @(negedge clk);
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        rst = 1'b1;
        rd(4'h4, 32'h0000_0002);
        idle();
        edges = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) edges++;
        end
        chk("abort_no_resume", 32'(edges), 32'd0);

        idle();
        chk("pending_bytes", 32'(byte_q.size()), 32'd0);
        chk("pending_reads", 32'(rd_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 Parameter CLK_DIV, default 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 8, transmit FIFO entries; power of two, 2..64.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; 0 = reset asserted, 1 = run.
REQ-005 wr_en  input  1  core store strobe, one cycle per store.
REQ-006 rd_en  input  1  core load strobe, one cycle per load.
REQ-007 addr  input  4  word offset: 0x0 TXDATA, 0x4 STATUS, 0x8 CTRL; other offsets reserved.
REQ-008 wdata  input  32  store data.
REQ-009 rdata  output  32  load data, registered.
REQ-010 tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-011 busy  output  1  high while FIFO non-empty or a frame is in flight.

Function
REQ-012 Store to TXDATA SHALL push wdata[7:0] into the FIFO when not full; wdata[31:8] ignored.
REQ-013 Store to TXDATA while full SHALL drop the byte and set sticky overflow; FIFO contents unchanged.
REQ-014 Full SHALL be evaluated on pre-edge occupancy: a push and a pop in the same cycle at full drops the push.
REQ-015 Store to CTRL with wdata[0]=1 SHALL clear overflow; stores to STATUS or reserved offsets have no effect.
REQ-016 Load SHALL drive rdata on the cycle after rd_en and hold it until the next load.
REQ-017 STATUS layout: bit0 full, bit1 empty, bit2 tx_active, bit3 overflow, bits[10:4] occupancy, remaining bits 0.
REQ-018 Loads from TXDATA, CTRL, or reserved offsets SHALL return 0.
REQ-019 Simultaneous wr_en and rd_en SHALL both be serviced; a read of STATUS reflects pre-edge state.
REQ-020 FSM states: IDLE, START, DATA, STOP.
REQ-021 IDLE -> START when FIFO non-empty; pop the head into an 8-bit shift register on that edge.
REQ-022 START drives tx=0 for CLK_DIV cycles, then -> DATA.
REQ-023 DATA drives shift[0] for CLK_DIV cycles per bit, shifts right, and counts bits 0..7; after bit 7 -> STOP.
REQ-024 STOP drives tx=1 for CLK_DIV cycles, then -> START if FIFO non-empty (back-to-back, no idle gap), else -> IDLE.
REQ-025 A frame SHALL be exactly 10*CLK_DIV cycles; the baud counter reloads to CLK_DIV-1 at every bit boundary.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked with log2(FIFO_DEPTH)+1 bits.
REQ-027 tx and busy SHALL be registered outputs (glitch-free).

Reset
REQ-028 While rst=0: tx=1, busy=0, rdata=0, FSM=IDLE, FIFO empty, overflow=0, counters=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, with tx high within the same reset assertion; no resumption after release.
REQ-030 First push is accepted on the first rising edge after rst rises.

Structure
REQ-031 Shared package rv32i_mmio_pkg SHALL hold the register offsets (TXDATA, STATUS, CTRL), the STATUS bit positions, and the FSM state enum.
REQ-032 The FIFO SHALL be a separate sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count); the FSM, baud counter, and register decode reside in uart_tx_mmio.

Verification (CLK_DIV=4, FIFO_DEPTH=4)
REQ-033 Reset: hold rst=0 for 2 cycles -> tx=1, busy=0, STATUS read = 0x0000_0002.
REQ-034 Store 0x55 to TXDATA -> tx low for cycles 1-4 after pop, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then high for 4; total 40 cycles; busy falls after the stop bit.
REQ-035 Store 0xA5, then 0x3C, on consecutive cycles -> two frames totalling 80 cycles with no idle gap between them; decoded bytes 0xA5, 0x3C.
REQ-036 Store 6 bytes back-to-back while the FSM is busy with the first -> bytes 1-5 are sent, byte 6 is dropped, STATUS bit3=1; store CTRL=1 -> bit3=0.
REQ-037 Assert rst=0 at cycle 15 of a frame -> tx=1 during reset, STATUS empty after release, no further edges on tx.
REQ-038 Read STATUS when 2 entries are queued -> rdata=0x0000_0024 one cycle after rd_en (bit2 set while a frame is active).
